memory_bus_sequencer: RTL and testbench

Multi-cycle controller between the single-cycle CPU's 32-bit load/store port and the 8-bit external pin bus. It accepts one word request, runs four byte transfers with a strobe/acknowledge handshake and per-byte timeout, then returns the assembled read word. It stalls the CPU for the duration of each transaction.

---
 rtl/memory_bus_sequencer.sv | 157 +++++++++++++++
 tb/tb_memory_bus_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_sequencer.sv
// memory_bus_sequencer
// Bridges the CPU's single-cycle 32-bit load/store port onto the 8-bit
// external pin bus. One word request becomes four byte transfers, each with a
// strobe/acknowledge handshake and a per-byte timeout. The CPU is stalled for
// the whole transaction and released in the cycle the response is presented.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for request_valid; latches the request when it comes
// TRANSFER | strobing byte byte_index until acknowledge or timeout
// DONE     | one-cycle response pulse; CPU released
module memory_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  input  logic        request_write,
  input  logic [31:0] request_address,
  input  logic [31:0] request_write_data,
  output logic        stall,
  output logic        response_valid,
  output logic [31:0] response_read_data,
  output logic        response_error,
  output logic [7:0]  bus_address,
  output logic [7:0]  bus_write_data,
  input  logic [7:0]  bus_read_data,
  output logic [7:0]  bus_output_enable,
  output logic        bus_strobe,
  input  logic        bus_acknowledge
);

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    DONE
  } state_t;

  // wait_count value on which an unacknowledged byte is abandoned
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        latched_write, latched_write_next;
  logic [5:0]  latched_address, latched_address_next;
  logic [31:0] latched_data, latched_data_next;
  logic [1:0]  byte_index, byte_index_next;
  logic [7:0]  wait_count, wait_count_next;
  logic        error_flag, error_flag_next;
  logic [31:0] read_word, read_word_next;
  logic        advance;
  logic [4:0]  lane_lsb;

  assign lane_lsb = {byte_index, 3'b000};

  // State and datapath registers; async reset returns everything to idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      latched_write   <= 1'b0;
      latched_address <= 6'd0;
      latched_data    <= 32'd0;
      byte_index      <= 2'd0;
      wait_count      <= 8'd0;
      error_flag      <= 1'b0;
      read_word       <= 32'd0;
    end else begin
      state           <= state_next;
      latched_write   <= latched_write_next;
      latched_address <= latched_address_next;
      latched_data    <= latched_data_next;
      byte_index      <= byte_index_next;
      wait_count      <= wait_count_next;
      error_flag      <= error_flag_next;
      read_word       <= read_word_next;
    end
  end

  // Next-state and output decode; bus outputs depend only on registered state
  always_comb begin
    state_next           = state;
    latched_write_next   = latched_write;
    latched_address_next = latched_address;
    latched_data_next    = latched_data;
    byte_index_next      = byte_index;
    wait_count_next      = wait_count;
    error_flag_next      = error_flag;
    read_word_next       = read_word;
    advance              = 1'b0;

    stall              = request_valid & (state != DONE);
    response_valid     = 1'b0;
    response_read_data = 32'd0;
    response_error     = 1'b0;
    bus_address        = 8'd0;
    bus_write_data     = 8'd0;
    bus_output_enable  = 8'h00;
    bus_strobe         = 1'b0;

    case (state)
      IDLE: begin
        if (request_valid) begin
          latched_write_next   = request_write;
          latched_address_next = request_address[7:2];
          latched_data_next    = request_write_data;
          byte_index_next      = 2'd0;
          wait_count_next      = 8'd0;
          error_flag_next      = 1'b0;
          read_word_next       = 32'd0;
          state_next           = TRANSFER;
        end
      end

      TRANSFER: begin
        bus_strobe        = 1'b1;
        bus_address       = {latched_address, byte_index};
        bus_write_data    = latched_data[lane_lsb +: 8];
        bus_output_enable = latched_write ? 8'hFF : 8'h00;

        // acknowledge takes priority over a coincident timeout
        if (bus_acknowledge) begin
          if (!latched_write) begin
            read_word_next[lane_lsb +: 8] = bus_read_data;
          end
          wait_count_next = 8'd0;
          advance         = 1'b1;
        end else if (wait_count == LAST_WAIT) begin
          read_word_next[lane_lsb +: 8] = 8'h00;
          error_flag_next = 1'b1;
          wait_count_next = 8'd0;
          advance         = 1'b1;
        end else begin
          wait_count_next = wait_count + 8'd1;
        end

        if (advance) begin
          if (byte_index == 2'd3) begin
            state_next = DONE;
          end else begin
            byte_index_next = byte_index + 2'd1;
          end
        end
      end

      DONE: begin
        response_valid     = 1'b1;
        response_read_data = read_word;
        response_error     = error_flag;
        state_next         = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_bus_sequencer.sv
// Bench for memory_bus_sequencer: a bus target model with per-byte wait
// counts, a response scoreboard filled when each request is issued, and
// per-cycle checks of the strobe/address/data/enable outputs.
module tb_memory_bus_sequencer;

  localparam int T = 3;

  logic        clock;
  logic        reset;
  logic        request_valid;
  logic        request_write;
  logic [31:0] request_address;
  logic [31:0] request_write_data;
  logic        stall;
  logic        response_valid;
  logic [31:0] response_read_data;
  logic        response_error;
  logic [7:0]  bus_address;
  logic [7:0]  bus_write_data;
  logic [7:0]  bus_read_data;
  logic [7:0]  bus_output_enable;
  logic        bus_strobe;
  logic        bus_acknowledge;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  memory_bus_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clock              (clock),
    .reset              (reset),
    .request_valid      (request_valid),
    .request_write      (request_write),
    .request_address    (request_address),
    .request_write_data (request_write_data),
    .stall              (stall),
    .response_valid     (response_valid),
    .response_read_data (response_read_data),
    .response_error     (response_error),
    .bus_address        (bus_address),
    .bus_write_data     (bus_write_data),
    .bus_read_data      (bus_read_data),
    .bus_output_enable  (bus_output_enable),
    .bus_strobe         (bus_strobe),
    .bus_acknowledge    (bus_acknowledge)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE. wN is the number of
  // strobe cycles the target waits before acknowledging byte N; wN >= T means
  // the byte is never acknowledged and must time out.
  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int w0, input int w1, input int w2, input int w3,
                         input bit keep_valid);
    int    waits[4];
    resp_t exp_r;
    resp_t got;
    int    lat;
    int    bi;
    int    held;
    int    cyc;
    logic  done;
    logic [1:0] bi2;

    waits = '{w0, w1, w2, w3};
    exp_r.data = 32'd0;
    exp_r.err  = 1'b0;
    lat = 2;
    for (int b = 0; b < 4; b++) begin
      if (waits[b] < T) begin
        lat += waits[b] + 1;
        if (!wr) exp_r.data[8*b +: 8] = rdata[8*b +: 8];
      end else begin
        lat += T;
        exp_r.err = 1'b1;
      end
    end
    sb_q.push_back(exp_r);

    request_valid      = 1'b1;
    request_write      = wr;
    request_address    = addr;
    request_write_data = wdata;
    #1;
    check_value("idle_stall", {31'd0, stall}, 32'd1);
    check_value("idle_strobe", {31'd0, bus_strobe}, 32'd0);

    bi = 0; held = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (cyc == 2) begin
        request_write      = ~wr;
        request_address    = ~addr;
        request_write_data = ~wdata;
      end
      if (bi < 4) begin
        bi2 = bi[1:0];
        check_value("strobe", {31'd0, bus_strobe}, 32'd1);
        check_value("bus_address", {24'd0, bus_address}, {24'd0, addr[7:2], bi2});
        check_value("bus_write_data", {24'd0, bus_write_data}, {24'd0, wdata[8*bi +: 8]});
        check_value("output_enable", {24'd0, bus_output_enable}, wr ? 32'hFF : 32'h00);
        check_value("busy_stall", {31'd0, stall}, 32'd1);
        check_value("busy_resp", {31'd0, response_valid}, 32'd0);
        bus_read_data   = rdata[8*bi +: 8];
        bus_acknowledge = (held == waits[bi]);
        if (bus_acknowledge || held == T - 1) begin
          bi++;
          held = 0;
        end else begin
          held++;
        end
      end else begin
        bus_acknowledge = 1'b0;
        bus_read_data   = 8'h00;
        check_value("resp_valid", {31'd0, response_valid}, 32'd1);
        check_value("done_stall", {31'd0, stall}, 32'd0);
        check_value("done_strobe", {31'd0, bus_strobe}, 32'd0);
        check_value("done_oe", {24'd0, bus_output_enable}, 32'd0);
        check_value("latency", cyc, lat - 1);
        if (sb_q.size() == 0) begin
          check_value("sb_nonempty", sb_q.size(), 1);
        end else begin
          got = sb_q.pop_front();
          check_value("read_data", response_read_data, got.data);
          check_value("resp_error", {31'd0, response_error}, {31'd0, got.err});
        end
        done = 1'b1;
      end
    end
    check_value("txn_done", {31'd0, done}, 32'd1);
    if (!keep_valid) request_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset              = 1'b1;
    request_valid      = 1'b0;
    request_write      = 1'b0;
    request_address    = 32'd0;
    request_write_data = 32'd0;
    bus_read_data      = 8'h00;
    bus_acknowledge    = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_value("rst_stall", {31'd0, stall}, 32'd0);
    check_value("rst_strobe", {31'd0, bus_strobe}, 32'd0);
    check_value("rst_oe", {24'd0, bus_output_enable}, 32'd0);
    check_value("rst_resp", {31'd0, response_valid}, 32'd0);
    check_value("rst_addr", {24'd0, bus_address}, 32'd0);
    reset = 1'b0;

    // no request: stays idle, never strobes
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_value("idle_no_strobe", {31'd0, bus_strobe}, 32'd0);
      check_value("idle_no_stall", {31'd0, stall}, 32'd0);
    end

    // zero-wait load
    run_txn(1'b0, 32'h14, 32'h0, 32'h44332211, 0, 0, 0, 0, 1'b0);
    // store with 2 waits per byte (ack lands in the final timeout cycle)
    run_txn(1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 2, 2, 2, 2, 1'b0);
    // load, ack in final timeout cycle on every byte: all bytes captured
    run_txn(1'b0, 32'h2C, 32'h0, 32'h89ABCDEF, 2, 2, 2, 2, 1'b0);
    // byte 2 never acknowledged
    run_txn(1'b0, 32'h40, 32'h0, 32'hDDCCBBAA, 0, 0, 255, 0, 1'b0);
    // worst case: store where every byte times out
    run_txn(1'b1, 32'h3C, 32'hCAFEF00D, 32'h0, 255, 255, 255, 255, 1'b0);
    // error flag cleared by the next transaction
    run_txn(1'b0, 32'hFC, 32'h0, 32'hA5A55A5A, 0, 1, 0, 1, 1'b0);

    // reset during byte 1 of a store
    request_valid      = 1'b1;
    request_write      = 1'b1;
    request_address    = 32'h30;
    request_write_data = 32'h12345678;
    bus_acknowledge    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_value("pre_rst_addr0", {24'd0, bus_address}, 32'h30);
    @(posedge clock);
    @(negedge clock);
    check_value("pre_rst_addr1", {24'd0, bus_address}, 32'h31);
    reset = 1'b1;
    #1;
    check_value("mid_rst_strobe", {31'd0, bus_strobe}, 32'd0);
    check_value("mid_rst_oe", {24'd0, bus_output_enable}, 32'd0);
    check_value("mid_rst_stall", {31'd0, stall}, 32'd1);
    request_valid   = 1'b0;
    bus_acknowledge = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_value("post_rst_strobe", {31'd0, bus_strobe}, 32'd0);
    check_value("post_rst_resp", {31'd0, response_valid}, 32'd0);
    run_txn(1'b0, 32'h14, 32'h0, 32'h0F1E2D3C, 1, 0, 1, 0, 1'b0);

    // back-to-back loads with request_valid held; misaligned second address
    run_txn(1'b0, 32'h20, 32'h0, 32'h55667788, 0, 0, 0, 0, 1'b1);
    run_txn(1'b0, 32'h23, 32'h0, 32'h55667788, 0, 0, 0, 0, 1'b0);

    check_value("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
